// File: rtl/prim_flop_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : prim_flop_wr_arb
// Purpose  : Round-robin write arbiter sharing one async-reset state register
//            between NumReq requesters, with bounded back-to-back locking.
// Revision : 1.0 - initial release
// ============================================================================

module prim_flop_wr_arb #(
    parameter int unsigned      NumReq     = 4,
    parameter int unsigned      Width      = 32,
    parameter logic [Width-1:0] ResetValue = '0,
    parameter int unsigned      MaxLock    = 4,
    localparam int unsigned     IdxW       = $clog2(NumReq)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumReq-1:0]       req_i,
    input  logic [NumReq-1:0]       lock_i,
    input  logic [NumReq*Width-1:0] data_i,
    output logic [NumReq-1:0]       gnt_o,
    output logic [Width-1:0]        q_o,
    output logic                    wr_valid_o,
    output logic [IdxW-1:0]         wr_idx_o,
    output logic                    locked_o
);

    localparam logic [0:0]      c_ST_IDLE   = 1'b0;
    localparam logic [0:0]      c_ST_LOCKED = 1'b1;
    localparam bit              c_LOCK_EN   = (MaxLock > 1);
    localparam logic [7:0]      c_MAX_LOCK  = 8'(MaxLock);
    localparam int unsigned     c_SUM_W     = IdxW + 1;
    localparam logic [IdxW-1:0] c_LAST_IDX  = IdxW'(NumReq - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [IdxW-1:0]  r_owner;
    logic [IdxW-1:0]  w_owner_nxt;
    logic [IdxW-1:0]  r_ptr;
    logic [IdxW-1:0]  w_ptr_nxt;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_nxt;
    logic [Width-1:0] r_q;
    logic             r_wr_valid;
    logic [IdxW-1:0]  r_wr_idx;

    logic             w_lock_hold;
    logic             w_gnt_any;
    logic [IdxW-1:0]  w_gnt_idx;
    logic [Width-1:0] w_wdata;
    logic [IdxW-1:0]  w_cand [NumReq];

    function automatic logic [IdxW-1:0] inc_wrap(input logic [IdxW-1:0] v);
        return (v == c_LAST_IDX) ? '0 : v + IdxW'(1);
    endfunction

    // w_cand[g] is the requester index at priority rank g, counting up from r_ptr.
    for (genvar g = 0; g < NumReq; g++) begin : g_cand
        logic [c_SUM_W-1:0] w_sum;
        assign w_sum     = {1'b0, r_ptr} + c_SUM_W'(g);
        assign w_cand[g] = (w_sum >= c_SUM_W'(NumReq)) ? IdxW'(w_sum - c_SUM_W'(NumReq))
                                                        : w_sum[IdxW-1:0];
    end

    // A lock only holds while its owner keeps requesting; otherwise normal arbitration.
    assign w_lock_hold = (r_state == c_ST_LOCKED) && req_i[r_owner];

    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        if (w_lock_hold) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = r_owner;
        end else begin
            for (int i = 0; i < NumReq; i++) begin
                if (!w_gnt_any && req_i[w_cand[i]]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = w_cand[i];
                end
            end
        end
    end

    always_comb begin
        gnt_o   = '0;
        w_wdata = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (w_gnt_any && (w_gnt_idx == IdxW'(k))) begin
                gnt_o[k] = 1'b1;
                w_wdata  = data_i[k*Width +: Width];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_ST_IDLE;
            r_owner <= '0;
            r_cnt   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        if (w_lock_hold) begin
            w_cnt_nxt = 8'(r_cnt + 8'd1);
            if (!lock_i[r_owner] || (8'(r_cnt + 8'd1) == c_MAX_LOCK)) begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
                w_ptr_nxt   = inc_wrap(r_owner);
            end
        end else begin
            w_state_nxt = c_ST_IDLE;
            w_cnt_nxt   = '0;
            if (r_state == c_ST_LOCKED) begin
                w_ptr_nxt = inc_wrap(r_owner);
            end
            if (w_gnt_any) begin
                w_ptr_nxt = inc_wrap(w_gnt_idx);
                if (c_LOCK_EN && lock_i[w_gnt_idx]) begin
                    w_state_nxt = c_ST_LOCKED;
                    w_owner_nxt = w_gnt_idx;
                    w_cnt_nxt   = 8'd1;
                end
            end
        end
    end

    // FSM: outputs
    always_comb begin
        locked_o = (r_state == c_ST_LOCKED);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q        <= ResetValue;
            r_wr_valid <= 1'b0;
            r_wr_idx   <= '0;
        end else begin
            r_wr_valid <= w_gnt_any;
            if (w_gnt_any) begin
                r_q      <= w_wdata;
                r_wr_idx <= w_gnt_idx;
            end
        end
    end

    assign q_o        = r_q;
    assign wr_valid_o = r_wr_valid;
    assign wr_idx_o   = r_wr_idx;

endmodule

`default_nettype wire

// File: tb/tb_prim_flop_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_prim_flop_wr_arb
// Purpose  : Self-checking bench for prim_flop_wr_arb with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_prim_flop_wr_arb;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int ML = 4;
    localparam int IW = 2;
    localparam logic [W-1:0] RV = '0;

    logic           clk_i  = 1'b0;
    logic           rst_ni = 1'b0;
    logic [N-1:0]   req_i  = '0;
    logic [N-1:0]   lock_i = '0;
    logic [N*W-1:0] data_i = '0;
    logic [N-1:0]   gnt_o;
    logic [W-1:0]   q_o;
    logic           wr_valid_o;
    logic [IW-1:0]  wr_idx_o;
    logic           locked_o;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit           m_locked;
    int           m_owner;
    int           m_cnt;
    int           m_ptr;
    logic [W-1:0] m_q;
    bit           m_wr_valid;
    int           m_wr_idx;
    int           m_g;

    prim_flop_wr_arb #(
        .NumReq    (N),
        .Width     (W),
        .ResetValue(RV),
        .MaxLock   (ML)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .lock_i    (lock_i),
        .data_i    (data_i),
        .gnt_o     (gnt_o),
        .q_o       (q_o),
        .wr_valid_o(wr_valid_o),
        .wr_idx_o  (wr_idx_o),
        .locked_o  (locked_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] one;
        one = 1;
        return (g < 0) ? '0 : (one << g);
    endfunction

    function automatic int model_grant();
        if (m_locked && req_i[m_owner]) return m_owner;
        for (int i = 0; i < N; i++) begin
            if (req_i[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
        m_q = RV; m_wr_valid = 0; m_wr_idx = 0;
    endtask

    task automatic model_step(input int g);
        if (m_locked && req_i[m_owner]) begin
            m_cnt++;
            if (!lock_i[m_owner] || m_cnt == ML) begin
                m_locked = 0;
                m_ptr    = (m_owner + 1) % N;
            end
        end else begin
            if (m_locked) m_ptr = (m_owner + 1) % N;
            m_locked = 0;
            if (g >= 0) begin
                m_ptr = (g + 1) % N;
                if (lock_i[g] && ML > 1) begin
                    m_locked = 1; m_owner = g; m_cnt = 1;
                end
            end
        end
        if (g >= 0) begin
            m_q = data_i[g*W +: W]; m_wr_valid = 1; m_wr_idx = g;
        end else begin
            m_wr_valid = 0;
        end
    endtask

    // Advances one clock edge and the model with it; leaves time at edge+1.
    task automatic tick();
        m_g = model_grant();
        @(posedge clk_i);
        model_step(m_g);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; req_i = '0; lock_i = '0;
        model_reset();
        repeat (5) @(posedge clk_i);
        #1;
        checks++; if (gnt_o !== '0) begin failures++; $display("FAIL reset_gnt: got %b exp 0", gnt_o); end
        checks++; if (q_o !== RV) begin failures++; $display("FAIL reset_q: got %h exp %h", q_o, RV); end
        checks++; if (wr_valid_o !== 1'b0 || locked_o !== 1'b0 || wr_idx_o !== '0) begin
            failures++; $display("FAIL reset_flags: valid=%b locked=%b idx=%0d exp 0/0/0", wr_valid_o, locked_o, wr_idx_o);
        end
        @(negedge clk_i); rst_ni = 1'b1;
        #1; tick();
        checks++; if (q_o !== RV || wr_valid_o !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset: q=%h valid=%b exp %h/0", q_o, wr_valid_o, RV);
        end
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 8; i++) begin
            req_i = 4'b1111; lock_i = '0;
            for (int k = 0; k < N; k++) data_i[k*W +: W] = 32'hA0 + k;
            #1;
            checks++; if (gnt_o !== onehot(i % 4)) begin
                failures++; $display("FAIL rr_gnt cycle %0d: got %b exp %b", i, gnt_o, onehot(i % 4));
            end
            tick();
            checks++; if (q_o !== W'(32'hA0 + (i % 4))) begin
                failures++; $display("FAIL rr_q cycle %0d: got %h exp %h", i, q_o, 32'hA0 + (i % 4));
            end
            checks++; if (wr_valid_o !== 1'b1 || wr_idx_o !== IW'(i % 4)) begin
                failures++; $display("FAIL rr_wr cycle %0d: valid=%b idx=%0d exp 1/%0d", i, wr_valid_o, wr_idx_o, i % 4);
            end
        end
    endtask

    task automatic test_lock_burst();
        int exp_seq [10] = '{0, 1, 1, 1, 1, 2, 3, 0, 1, 1};
        for (int i = 0; i < 10; i++) begin
            req_i = 4'b1111; lock_i = 4'b0010;
            for (int k = 0; k < N; k++) data_i[k*W +: W] = 32'hB000 + 16 * i + k;
            #1;
            checks++; if (gnt_o !== onehot(exp_seq[i])) begin
                failures++; $display("FAIL lock_burst_gnt cycle %0d: got %b exp %b", i, gnt_o, onehot(exp_seq[i]));
            end
            tick();
            checks++; if (locked_o !== m_locked || q_o !== m_q) begin
                failures++; $display("FAIL lock_burst_state cycle %0d: locked=%b q=%h exp %b/%h", i, locked_o, q_o, m_locked, m_q);
            end
        end
    endtask

    task automatic test_lock_drop();
        req_i = '0; lock_i = '0; #1; tick();
        req_i = 4'b0100; lock_i = 4'b0100; data_i[2*W +: W] = 32'h2222_0001; #1;
        checks++; if (gnt_o !== 4'b0100) begin failures++; $display("FAIL drop_enter_gnt: got %b exp 0100", gnt_o); end
        tick();
        req_i = 4'b0101; #1;
        checks++; if (gnt_o !== 4'b0100) begin failures++; $display("FAIL drop_hold_gnt: got %b exp 0100", gnt_o); end
        tick();
        checks++; if (locked_o !== 1'b1) begin failures++; $display("FAIL drop_locked: got %b exp 1", locked_o); end
        req_i = 4'b0001; lock_i = '0; data_i[0 +: W] = 32'h0000_0A0A; #1;
        checks++; if (gnt_o !== 4'b0001) begin failures++; $display("FAIL drop_same_cycle_gnt: got %b exp 0001", gnt_o); end
        tick();
        checks++; if (locked_o !== 1'b0 || q_o !== 32'h0000_0A0A || wr_idx_o !== 2'd0) begin
            failures++; $display("FAIL drop_exit: locked=%b q=%h idx=%0d exp 0/00000a0a/0", locked_o, q_o, wr_idx_o);
        end
    endtask

    task automatic test_single_pulse();
        req_i = 4'b1000; lock_i = '0; data_i[3*W +: W] = 32'hDEADBEEF; data_i[0 +: W] = 32'h5555_5555; #1;
        checks++; if (gnt_o !== 4'b1000) begin failures++; $display("FAIL pulse_gnt: got %b exp 1000", gnt_o); end
        tick();
        req_i = '0;
        checks++; if (q_o !== 32'hDEADBEEF || wr_valid_o !== 1'b1 || wr_idx_o !== 2'd3) begin
            failures++; $display("FAIL pulse_write: q=%h valid=%b idx=%0d exp deadbeef/1/3", q_o, wr_valid_o, wr_idx_o);
        end
        #1; tick();
        checks++; if (q_o !== 32'hDEADBEEF || wr_valid_o !== 1'b0 || wr_idx_o !== 2'd3) begin
            failures++; $display("FAIL pulse_after: q=%h valid=%b idx=%0d exp deadbeef/0/3", q_o, wr_valid_o, wr_idx_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            req_i  = 4'($urandom_range(0, 15));
            lock_i = 4'($urandom_range(0, 15));
            for (int k = 0; k < N; k++) data_i[k*W +: W] = $urandom;
            #1;
            checks++; if (gnt_o !== onehot(model_grant())) begin
                failures++; $display("FAIL rand_gnt cycle %0d: got %b exp %b", i, gnt_o, onehot(model_grant()));
            end
            tick();
            checks++; if (q_o !== m_q || wr_valid_o !== m_wr_valid || wr_idx_o !== IW'(m_wr_idx) || locked_o !== m_locked) begin
                failures++;
                $display("FAIL rand_regs cycle %0d: q=%h valid=%b idx=%0d locked=%b exp %h/%b/%0d/%b",
                         i, q_o, wr_valid_o, wr_idx_o, locked_o, m_q, m_wr_valid, m_wr_idx, m_locked);
            end
        end
    endtask

    task automatic test_async_reset();
        req_i = '0; lock_i = '0; #1; tick();
        req_i = 4'b0010; lock_i = 4'b0010; data_i[1*W +: W] = 32'h1111_ABCD; data_i[0 +: W] = 32'h0F0F_0F0F;
        #1; tick(); tick();
        checks++; if (locked_o !== 1'b1 || q_o !== 32'h1111_ABCD) begin
            failures++; $display("FAIL arst_pre: locked=%b q=%h exp 1/1111abcd", locked_o, q_o);
        end
        #3 rst_ni = 1'b0;
        #1;
        model_reset();
        checks++; if (q_o !== RV || locked_o !== 1'b0 || wr_valid_o !== 1'b0) begin
            failures++; $display("FAIL arst_immediate: q=%h locked=%b valid=%b exp %h/0/0", q_o, locked_o, wr_valid_o, RV);
        end
        @(posedge clk_i); #1;
        checks++; if (q_o !== RV) begin failures++; $display("FAIL arst_held: q=%h exp %h", q_o, RV); end
        @(negedge clk_i); rst_ni = 1'b1; req_i = 4'b1111; lock_i = '0; #1;
        checks++; if (gnt_o !== 4'b0001) begin failures++; $display("FAIL arst_priority: got %b exp 0001", gnt_o); end
        tick();
        checks++; if (q_o !== 32'h0F0F_0F0F || wr_idx_o !== 2'd0 || locked_o !== 1'b0) begin
            failures++; $display("FAIL arst_first_write: q=%h idx=%0d locked=%b exp 0f0f0f0f/0/0", q_o, wr_idx_o, locked_o);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock_burst();
        test_lock_drop();
        test_single_pulse();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prim_flop_wr_arb.md
Name: prim_flop_wr_arb

Overview:
- Round-robin write arbiter that shares one Width-bit state register (prim_flop-style, async-reset to ResetValue) between NumReq requesters.
- Each cycle at most one requester is granted, and its data is written into the shared register on the next clock edge.
- A bounded lock feature lets one requester perform back-to-back writes.
- Used wherever several FSMs or CSR paths must update one configuration or state flop bank.

Parameters:
- NumReq, 4, number of requesters (2..16).
- Width, 32, width of the shared register and of each requester's write data.
- ResetValue, 0, value loaded into the shared register on reset (Width bits).
- MaxLock, 4, maximum consecutive grants a locking requester may hold (1..255).
- IdxW, $clog2(NumReq), derived localparam, not overridable.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- req_i  input  NumReq  per-requester write request.
- lock_i  input  NumReq  per-requester lock request; only meaningful together with req_i.
- data_i  input  NumReq*Width  write data; requester k uses bits [k*Width +: Width].
- gnt_o  output  NumReq  one-hot grant, combinational from req_i and internal state.
- q_o  output  Width  shared register value.
- wr_valid_o  output  1  registered pulse: a write occurred on the previous edge.
- wr_idx_o  output  IdxW  registered index of the requester that performed the last write.
- locked_o  output  1  arbiter is in the LOCKED state.

Behaviour:
- Reset is asynchronous, active-low, on rst_ni; clock is clk_i. While reset is asserted, all state is forced regardless of the clock:
  - q_o=ResetValue, wr_valid_o=0, wr_idx_o=0, locked_o=0.
  - Round-robin pointer=0, so requester 0 has highest priority.
  - Lock counter=0, FSM=IDLE.
- gnt_o is purely combinational and has no reset value of its own. It is 0 whenever req_i==0 (including during reset) and never has more than one bit set.
- Write latency:
  - If gnt_o[k]=1 in cycle t, q_o takes data_i[k] at the edge ending cycle t.
  - In cycle t+1: wr_valid_o=1, wr_idx_o=k.
  - If no grant occurs in cycle t, q_o holds and wr_valid_o=0 in t+1. wr_idx_o holds its last value.
- Round-robin, FSM in IDLE:
  - Grant the first requesting index at or above ptr, searching upward with wrap-around.
  - After a grant to k, ptr becomes (k+1) mod NumReq.
  - With no grant, ptr holds.
- Lock FSM has two states, IDLE and LOCKED, plus a lock owner register and a consecutive-grant counter cnt.
- IDLE→LOCKED when granted requester k has lock_i[k]=1 and MaxLock>1. Then owner=k and cnt=1.
- In LOCKED:
  - If req_i[owner]=1, grant owner irrespective of other requests, cnt++, and ptr is not advanced.
  - Exit to IDLE when any of these holds: req_i[owner]=0; lock_i[owner]=0 in a granted cycle (that grant still completes); or cnt reaches MaxLock after a grant.
  - On exit, ptr=(owner+1) mod NumReq, so the owner gets lowest priority next.
  - If req_i[owner]=0 in a LOCKED cycle, that cycle is arbitrated as IDLE in the same cycle (no dead cycle) and the FSM returns to IDLE.
- locked_o=1 exactly while the FSM is LOCKED (registered).
- MaxLock=1: lock_i is ignored and the FSM never leaves IDLE.
- lock_i[k] without req_i[k] has no effect.
- data_i is sampled only from the granted requester; data from non-granted requesters never reaches q_o.
- Reset asserted mid-lock or mid-write: immediate return to the reset state. Any in-flight write is dropped, and q_o shows ResetValue.

Test Plan:
- Reset, then req_i=4'b0000 for 5 cycles -> q_o=0, gnt_o=0, wr_valid_o=0, locked_o=0.
- req_i=4'b1111 held for 8 cycles, data_i[k]=32'hA0+k -> grants 0,1,2,3,0,1,2,3; q_o sequence A0,A1,A2,A3,...; wr_idx_o lags the grant by one cycle.
- Requester 1 with req=1 and lock=1 for 10 cycles, others requesting, MaxLock=4 -> requester 1 granted 4 consecutive cycles with locked_o=1; then grants go 2,3,0 before requester 1 again.
- Requester 2 locks, then drops req_i[2] in its 2nd locked cycle while req_i[0]=1 -> requester 0 granted in that same cycle; locked_o=0 the next cycle.
- Single requester 3 pulses req for 1 cycle, data 32'hDEADBEEF -> q_o=DEADBEEF one edge later; wr_valid_o is a one-cycle pulse with wr_idx_o=3.
- Assert rst_ni=0 asynchronously mid-clock during a LOCKED burst -> q_o=ResetValue, locked_o=0, wr_valid_o=0 immediately; after release, requester 0 has highest priority.
